// File: rtl/seek_timing_controller.sv
// rtl/seek_timing_controller.sv - paces emulated head stepping and settle, gating bus ready
module seek_timing_controller #(
    parameter int STEP_TICKS   = 2,
    parameter int SETTLE_TICKS = 3,
    parameter int MAX_CYL      = 202
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       clkenbl_tick,
    input  logic       Selected_Ready,
    input  logic       seek_start,
    input  logic       restore,
    input  logic [7:0] target_cyl,
    output logic [7:0] current_cyl,
    output logic       BUS_RWS_RDY_H,
    output logic       seek_busy,
    output logic       seek_done,
    output logic       seek_ignored,
    output logic       oncylinder_indicator
);

    localparam logic [7:0] STEP_LIM   = 8'(STEP_TICKS);
    localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_TICKS);
    localparam logic [7:0] MAX_C      = 8'(MAX_CYL);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_SETTLE, S_DONE} state_t;

    state_t     r_state, w_next;
    logic [7:0] r_tgt, w_tgt_next;
    logic [7:0] r_tcnt, w_tcnt_next;
    logic [7:0] r_cyl, w_cyl_next;
    logic [7:0] w_tcnt_inc, w_cyl_step, w_req_tgt;
    logic       w_in_range, w_ignore;
    logic       r_rdy, r_busy, r_done, r_ign, r_oncyl;

    // Saturating counter so a pathological limit can never wrap back through zero.
    assign w_tcnt_inc = (r_tcnt == 8'hFF) ? 8'hFF : r_tcnt + 8'd1;
    assign w_cyl_step = (r_tgt > r_cyl) ? r_cyl + 8'd1 : r_cyl - 8'd1;
    assign w_req_tgt  = restore ? 8'd0 : target_cyl;
    assign w_in_range = restore || (target_cyl <= MAX_C);

    always_comb begin
        w_next      = r_state;
        w_tgt_next  = r_tgt;
        w_tcnt_next = r_tcnt;
        w_cyl_next  = r_cyl;
        w_ignore    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (seek_start && Selected_Ready) begin
                    if (w_in_range) begin
                        w_tgt_next  = w_req_tgt;
                        w_tcnt_next = 8'd0;
                        w_next      = (w_req_tgt != r_cyl) ? S_STEP : S_SETTLE;
                    end else begin
                        w_ignore = 1'b1;
                    end
                end
            end
            S_STEP: begin
                if (!Selected_Ready) begin
                    w_next = S_IDLE;
                end else begin
                    w_ignore = seek_start;
                    if (clkenbl_tick) begin
                        if (w_tcnt_inc == STEP_LIM) begin
                            w_tcnt_next = 8'd0;
                            w_cyl_next  = w_cyl_step;
                            if (w_cyl_step == r_tgt) w_next = S_SETTLE;
                        end else begin
                            w_tcnt_next = w_tcnt_inc;
                        end
                    end
                end
            end
            S_SETTLE: begin
                if (!Selected_Ready) begin
                    w_next = S_IDLE;
                end else begin
                    w_ignore = seek_start;
                    if (clkenbl_tick) begin
                        w_tcnt_next = w_tcnt_inc;
                        if (w_tcnt_inc == SETTLE_LIM) w_next = S_DONE;
                    end
                end
            end
            default: begin
                w_ignore = seek_start && Selected_Ready;
                w_next   = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            r_state <= S_IDLE;
            r_tgt   <= 8'd0;
            r_tcnt  <= 8'd0;
            r_cyl   <= 8'd0;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ign   <= 1'b0;
            r_oncyl <= 1'b1;
        end else begin
            r_state <= w_next;
            r_tgt   <= w_tgt_next;
            r_tcnt  <= w_tcnt_next;
            r_cyl   <= w_cyl_next;
            r_rdy   <= Selected_Ready && (w_next == S_IDLE);
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            r_ign   <= w_ignore;
            r_oncyl <= (w_next == S_IDLE) || (w_next == S_DONE);
        end
    end

    assign current_cyl          = r_cyl;
    assign BUS_RWS_RDY_H        = r_rdy;
    assign seek_busy            = r_busy;
    assign seek_done            = r_done;
    assign seek_ignored         = r_ign;
    assign oncylinder_indicator = r_oncyl;

endmodule

// File: tb/tb_seek_timing_controller.sv
// tb/tb_seek_timing_controller.sv - scoreboard bench for seek_timing_controller
module tb_seek_timing_controller;

    localparam int STEP   = 2;
    localparam int SETTLE = 3;
    localparam int MAXC   = 202;

    logic       clock = 1'b0;
    logic       reset_L = 1'b0;
    logic       clkenbl_tick = 1'b0;
    logic       Selected_Ready = 1'b0;
    logic       seek_start = 1'b0;
    logic       restore = 1'b0;
    logic [7:0] target_cyl = 8'd0;
    logic [7:0] current_cyl;
    logic       BUS_RWS_RDY_H, seek_busy, seek_done, seek_ignored, oncylinder_indicator;

    seek_timing_controller #(.STEP_TICKS(STEP), .SETTLE_TICKS(SETTLE), .MAX_CYL(MAXC)) dut (
        .clock(clock), .reset_L(reset_L), .clkenbl_tick(clkenbl_tick),
        .Selected_Ready(Selected_Ready), .seek_start(seek_start), .restore(restore),
        .target_cyl(target_cyl), .current_cyl(current_cyl), .BUS_RWS_RDY_H(BUS_RWS_RDY_H),
        .seek_busy(seek_busy), .seek_done(seek_done), .seek_ignored(seek_ignored),
        .oncylinder_indicator(oncylinder_indicator)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        bit         is_done;
        logic [7:0] cyl;
        int         tick;
    } ev_t;

    ev_t        exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         tick_rel = 0;
    int         cyc = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] prev_cyl = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    initial forever begin
        @(negedge clock);
        cyc++;
        clkenbl_tick = (cyc % 4 == 0);
    end

    // Scoreboard: compare every head step and seek_done against queued expectations.
    always @(posedge clock) begin
        #1;
        if (!reset_L) begin
            tick_rel  = 0;
            prev_busy = 1'b0;
            prev_cyl  = current_cyl;
            exp_q.delete();
        end else begin
            if (seek_busy && !prev_busy) tick_rel = 0;
            else if (clkenbl_tick) tick_rel++;
            if (current_cyl !== prev_cyl || seek_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event_cyl", 32'(current_cyl), 32'(prev_cyl));
                    chk("unexpected_event_done", 32'(seek_done), 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("event_kind", 32'(seek_done), 32'(e.is_done));
                    chk("event_cyl", 32'(current_cyl), 32'(e.cyl));
                    chk("event_tick", 32'(tick_rel), 32'(e.tick));
                end
            end
            prev_busy = seek_busy;
            prev_cyl  = current_cyl;
        end
    end

    task automatic push_seek(input int from, input int to, input int upto_steps);
        int d, dir, c;
        ev_t e;
        d   = (to > from) ? to - from : from - to;
        dir = (to > from) ? 1 : -1;
        c   = from;
        for (int k = 1; k <= d && k <= upto_steps; k++) begin
            c += dir;
            e.is_done = 1'b0; e.cyl = 8'(c); e.tick = k * STEP;
            exp_q.push_back(e);
        end
        if (upto_steps >= d) begin
            e.is_done = 1'b1; e.cyl = 8'(to); e.tick = d * STEP + SETTLE;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_seek(input logic [7:0] tgt, input logic rst);
        @(negedge clock);
        chk("pre_accept_rdy", 32'(BUS_RWS_RDY_H), 32'd1);
        seek_start = 1'b1; restore = rst; target_cyl = tgt;
        @(negedge clock);
        seek_start = 1'b0; restore = 1'b0;
        chk("accept_busy", 32'(seek_busy), 32'd1);
        chk("accept_rdy", 32'(BUS_RWS_RDY_H), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (seek_done !== 1'b1 && n < 4000) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_done"}, 32'(seek_done), 32'd1);
        chk({tag, "_rdy_during_done"}, 32'(BUS_RWS_RDY_H), 32'd0);
        @(negedge clock);
        chk({tag, "_done_width"}, 32'(seek_done), 32'd0);
        chk({tag, "_rdy_release"}, 32'(BUS_RWS_RDY_H), 32'd1);
        chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_cyl(input logic [7:0] v);
        int n = 0;
        while (current_cyl !== v && n < 4000) begin
            @(negedge clock);
            n++;
        end
        chk("wait_cyl", 32'(current_cyl), 32'(v));
    endtask

    initial begin
        Selected_Ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_cyl", 32'(current_cyl), 32'd0);
        chk("rst_rdy", 32'(BUS_RWS_RDY_H), 32'd0);
        chk("rst_busy", 32'(seek_busy), 32'd0);
        chk("rst_done", 32'(seek_done), 32'd0);
        chk("rst_ign", 32'(seek_ignored), 32'd0);
        chk("rst_oncyl", 32'(oncylinder_indicator), 32'd1);
        reset_L = 1'b1;
        @(negedge clock);

        push_seek(0, 5, 999);
        start_seek(8'd5, 1'b0);
        chk("step_oncyl", 32'(oncylinder_indicator), 32'd0);
        wait_done("out_0_5");

        push_seek(5, 2, 999);
        start_seek(8'd2, 1'b0);
        wait_done("in_5_2");
        push_seek(2, 2, 999);
        start_seek(8'd2, 1'b0);
        wait_done("zero_2_2");

        @(negedge clock);
        seek_start = 1'b1; target_cyl = 8'd203;
        @(negedge clock);
        seek_start = 1'b0;
        chk("rej203_ign", 32'(seek_ignored), 32'd1);
        chk("rej203_busy", 32'(seek_busy), 32'd0);
        chk("rej203_cyl", 32'(current_cyl), 32'd2);
        @(negedge clock);
        chk("rej203_ign_width", 32'(seek_ignored), 32'd0);

        push_seek(2, 7, 999);
        start_seek(8'd7, 1'b0);
        wait_cyl(8'd4);
        seek_start = 1'b1; target_cyl = 8'd1;
        @(negedge clock);
        seek_start = 1'b0;
        chk("busy_rej_ign", 32'(seek_ignored), 32'd1);
        wait_done("busy_rej_2_7");

        push_seek(7, 200, 999);
        start_seek(8'd200, 1'b0);
        wait_done("out_7_200");
        push_seek(200, 0, 999);
        start_seek(8'h55, 1'b1);
        wait_done("restore_200_0");

        push_seek(0, 10, 3);
        start_seek(8'd10, 1'b0);
        wait_cyl(8'd3);
        Selected_Ready = 1'b0;
        @(negedge clock);
        chk("abort_busy", 32'(seek_busy), 32'd0);
        chk("abort_rdy", 32'(BUS_RWS_RDY_H), 32'd0);
        repeat (20) @(negedge clock);
        chk("abort_cyl", 32'(current_cyl), 32'd3);
        chk("abort_oncyl", 32'(oncylinder_indicator), 32'd1);
        chk("abort_queue", 32'(exp_q.size()), 32'd0);
        Selected_Ready = 1'b1;
        @(negedge clock);
        chk("abort_rdy_back", 32'(BUS_RWS_RDY_H), 32'd1);

        push_seek(3, 202, 999);
        start_seek(8'd202, 1'b0);
        wait_done("edge_3_202");

        push_seek(202, 200, 999);
        start_seek(8'd200, 1'b0);
        wait_cyl(8'd200);
        @(negedge clock);
        reset_L = 1'b0;
        @(negedge clock);
        chk("midrst_cyl", 32'(current_cyl), 32'd0);
        chk("midrst_rdy", 32'(BUS_RWS_RDY_H), 32'd0);
        chk("midrst_busy", 32'(seek_busy), 32'd0);
        chk("midrst_done", 32'(seek_done), 32'd0);
        chk("midrst_ign", 32'(seek_ignored), 32'd0);
        chk("midrst_oncyl", 32'(oncylinder_indicator), 32'd1);
        reset_L = 1'b1;
        repeat (30) @(negedge clock);
        chk("post_rst_rdy", 32'(BUS_RWS_RDY_H), 32'd1);
        chk("post_rst_busy", 32'(seek_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
